dmem_arbiter: RTL and testbench

- Shares one port of the data memory between two requesters: port 0 is the CPU load/store path, and port 1 is the bootloader or DMA path.
- Grants at most one access per cycle and drives the memory port from the winner.
- Returns read data to the owner one cycle later, matching the synchronous-read memory.
- Sits between the core, the load/store controller and the dmem port-A pins in the SoC top.

---
 rtl/soc_mem_pkg.sv | 21 ++
 rtl/arb_sel.sv | 41 ++++
 rtl/dmem_arbiter.sv | 133 +++++++++++++
 tb/tb_dmem_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_mem_pkg.sv
// Shared data-memory types: request payload struct and arbiter port identifiers.
// Widths here match the SoC's dmem instance; dmem_arbiter defaults to them.
package soc_mem_pkg;

    localparam int DMEM_ADDR_W = 10;
    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_STRB_W = DMEM_DATA_W / 8;

    typedef struct packed {
        logic                   we;
        logic [DMEM_STRB_W-1:0] strb;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
    } mem_req_t;

    typedef enum logic {
        ARB_CPU  = 1'b0,
        ARB_BOOT = 1'b1
    } arb_port_e;

endpackage

// File: rtl/arb_sel.sv
// Two-port grant selection. DMEM_ARB_RR_EN picks round-robin; otherwise fixed
// priority (CPU first) with a starvation override for the boot/DMA port.
module arb_sel
    import soc_mem_pkg::*;
(
    input  logic [1:0] req,
    input  arb_port_e  last,
    input  logic       starve,
    output logic [1:0] gnt
);

`ifdef DMEM_ARB_RR_EN
    logic unused_starve;
    assign unused_starve = starve;

    // On contention the port that did not win last time goes first.
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = (last == ARB_BOOT) ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end
`else
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        gnt = 2'b00;
        if (starve && req[1]) begin
            gnt = 2'b10;
        end else if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one synchronous-read dmem port between the CPU (port 0) and boot/DMA (port 1).
// Build option DMEM_ARB_RR_EN replaces fixed priority + starvation counter with round-robin.
module dmem_arbiter
    import soc_mem_pkg::*;
#(
    parameter int ADDR_WIDTH   = DMEM_ADDR_W,
    parameter int DATA_WIDTH   = DMEM_DATA_W,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    m0_req,
    input  logic                    m0_we,
    input  logic [DATA_WIDTH/8-1:0] m0_strb,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    output logic                    m0_gnt,
    output logic                    m0_rvalid,
    output logic [DATA_WIDTH-1:0]   m0_rdata,

    input  logic                    m1_req,
    input  logic                    m1_we,
    input  logic [DATA_WIDTH/8-1:0] m1_strb,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    output logic                    m1_gnt,
    output logic                    m1_rvalid,
    output logic [DATA_WIDTH-1:0]   m1_rdata,

    output logic                    mem_en,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_strb,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int STRB_W = DATA_WIDTH / 8;

    typedef struct packed {
        logic                  we;
        logic [STRB_W-1:0]     strb;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    req_t       m0_bus;
    req_t       m1_bus;
    req_t       mem_bus;
    logic [1:0] req_v;
    logic [1:0] gnt_v;
    logic       starve;
    arb_port_e  last_q;
    arb_port_e  rd_owner_q;
    logic       rd_pend_q;

    assign m0_bus = '{we: m0_we, strb: m0_strb, addr: m0_addr, wdata: m0_wdata};
    assign m1_bus = '{we: m1_we, strb: m1_strb, addr: m1_addr, wdata: m1_wdata};

    // Masking with rst_n keeps the memory port quiet while reset is held.
    assign req_v = {m1_req, m0_req} & {2{rst_n}};

`ifdef DMEM_ARB_RR_EN
    localparam int unused_starve_limit = STARVE_LIMIT;
    assign starve = 1'b0;
`else
    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;

    assign starve = (STARVE_LIMIT != 0) && (starve_cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!m1_req || gnt_v[1]) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`endif

    arb_sel u_sel (
        .req    (req_v),
        .last   (last_q),
        .starve (starve),
        .gnt    (gnt_v)
    );

    assign m0_gnt = gnt_v[0];
    assign m1_gnt = gnt_v[1];
    assign mem_en = |gnt_v;

    always_comb begin
        mem_bus = '0;
        if (gnt_v[0]) begin
            mem_bus = m0_bus;
        end else if (gnt_v[1]) begin
            mem_bus = m1_bus;
        end
    end

    assign mem_we    = mem_bus.we;
    assign mem_strb  = mem_bus.strb;
    assign mem_addr  = mem_bus.addr;
    assign mem_wdata = mem_bus.wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= ARB_CPU;
            last_q     <= ARB_BOOT;
        end else begin
            rd_pend_q <= mem_en & ~mem_bus.we;
            if (mem_en) begin
                last_q <= gnt_v[1] ? ARB_BOOT : ARB_CPU;
                if (!mem_bus.we) begin
                    rd_owner_q <= gnt_v[1] ? ARB_BOOT : ARB_CPU;
                end
            end
        end
    end

    // Read data is steered to the owner only; the other port sees zeros.
    assign m0_rvalid = rd_pend_q && (rd_owner_q == ARB_CPU);
    assign m1_rvalid = rd_pend_q && (rd_owner_q == ARB_BOOT);
    assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: cycle-by-cycle reference model plus directed scenarios.
// Honors DMEM_ARB_RR_EN for the round-robin build.
module tb_dmem_arbiter;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int SW    = DW / 8;
    localparam int LIMIT = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [SW-1:0] m0_strb;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [SW-1:0] m1_strb;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic          mem_en, mem_we;
    logic [SW-1:0] mem_strb;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_strb(m0_strb), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_strb(m1_strb), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_strb(mem_strb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [DW-1:0] preload(input int i);
        return (i == 4) ? 32'hDEADBEEF : (32'hA5A5_0000 | 32'(i));
    endfunction

    // Synchronous-read memory device attached to the arbiter's port.
    logic [DW-1:0] dev_mem [1024];
    logic [DW-1:0] dev_rd;
    assign mem_rdata = dev_rd;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < SW; b++)
                    if (mem_strb[b]) dev_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                dev_rd <= dev_mem[mem_addr];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: winner from the arbitration rules, a shadow memory,
    // and the read expected back on the following cycle.
    logic [DW-1:0] shadow [1024];
    int            m_wait  = 0;
    int            m_last  = 1;
    logic          m_pend  = 1'b0;
    int            m_owner = 0;
    logic [DW-1:0] m_pdata = '0;

    always @(negedge clk) begin
        int            win;
        logic          w_we;
        logic [SW-1:0] w_strb;
        logic [AW-1:0] w_addr;
        logic [DW-1:0] w_wdata;
        if (!rst_n) begin
            chk("rst_ctl", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_en, mem_we}, 0);
            chk("rst_bus", {mem_strb, mem_addr, mem_wdata}, 0);
            chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
            m_wait = 0;
            m_pend = 1'b0;
            m_last = 1;
        end else begin
            win = -1;
`ifdef DMEM_ARB_RR_EN
            if (m0_req && m1_req) win = (m_last == 1) ? 0 : 1;
            else if (m0_req)      win = 0;
            else if (m1_req)      win = 1;
`else
            if (m1_req && LIMIT != 0 && m_wait >= LIMIT) win = 1;
            else if (m0_req)                             win = 0;
            else if (m1_req)                             win = 1;
`endif
            w_we    = (win == 0) ? m0_we    : (win == 1) ? m1_we    : 1'b0;
            w_strb  = (win == 0) ? m0_strb  : (win == 1) ? m1_strb  : '0;
            w_addr  = (win == 0) ? m0_addr  : (win == 1) ? m1_addr  : '0;
            w_wdata = (win == 0) ? m0_wdata : (win == 1) ? m1_wdata : '0;

            chk("gnt", {m1_gnt, m0_gnt}, {(win == 1), (win == 0)});
            chk("mem_ctl", {mem_en, mem_we, mem_strb, mem_addr}, {(win >= 0), w_we, w_strb, w_addr});
            chk("mem_wdata", mem_wdata, w_wdata);
            chk("rvalid", {m1_rvalid, m0_rvalid}, {(m_pend && m_owner == 1), (m_pend && m_owner == 0)});
            chk("rdata0", m0_rdata, (m_pend && m_owner == 0) ? m_pdata : '0);
            chk("rdata1", m1_rdata, (m_pend && m_owner == 1) ? m_pdata : '0);

            if (m1_req && win != 1) m_wait = (m_wait < LIMIT) ? m_wait + 1 : m_wait;
            else                    m_wait = 0;
            if (win >= 0) m_last = win;
            m_pend = (win >= 0) && !w_we;
            if (m_pend) begin
                m_owner = win;
                m_pdata = shadow[w_addr];
            end
            if (win >= 0 && w_we)
                for (int b = 0; b < SW; b++)
                    if (w_strb[b]) shadow[w_addr][8*b +: 8] = w_wdata[8*b +: 8];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_req = 0; m0_we = 0; m0_strb = '0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_strb = '0; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic rd0(input logic [AW-1:0] a);
        m0_req = 1; m0_we = 0; m0_strb = '1; m0_addr = a; m0_wdata = '0;
    endtask

    task automatic rd1(input logic [AW-1:0] a);
        m1_req = 1; m1_we = 0; m1_strb = '1; m1_addr = a; m1_wdata = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    int first_m1, second_m1, first_m1_rv;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            dev_mem[i] = preload(i);
            shadow[i]  = preload(i);
        end
        dev_rd = '0;
        idle();
        rst_n = 0;
        // Requests during reset must not be granted.
        m0_req = 1; m1_req = 1;
        #1;
        chk("reset_gnt_masked", {m1_gnt, m0_gnt, mem_en}, 0);
        repeat (2) tick();
        idle();
        rst_n = 1;
        tick();

        // Single CPU read.
        rd0(10'h004);
        #1 chk("t1_gnt0", m0_gnt, 1);
        tick(); idle();
        #1 chk("t1_rvalid0", m0_rvalid, 1);
        chk("t1_rdata0", m0_rdata, 32'hDEADBEEF);
        chk("t1_rvalid1", m1_rvalid, 0);

        // Boot-port partial write, then read it back through the CPU port.
        m1_req = 1; m1_we = 1; m1_strb = 4'b0011; m1_addr = 10'h010; m1_wdata = 32'h12345678;
        #1 chk("t2_mem", {mem_we, mem_strb, mem_addr}, {1'b1, 4'b0011, 10'h010});
        chk("t2_wdata", mem_wdata, 32'h12345678);
        tick(); idle();
        #1 chk("t2_no_rvalid", {m1_rvalid, m0_rvalid}, 0);
        rd0(10'h010);
        tick(); idle();
        #1 chk("t2_readback", m0_rdata, 32'hA5A55678);

        // Continuous contention from a fresh reset.
        do_reset();
        rd0(10'h020); rd1(10'h021);
        first_m1 = -1; second_m1 = -1; first_m1_rv = -1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (m1_gnt && first_m1 < 0)         first_m1 = c;
            else if (m1_gnt && second_m1 < 0)   second_m1 = c;
            if (m1_rvalid && first_m1_rv < 0)   first_m1_rv = c;
            tick();
        end
        idle();
`ifdef DMEM_ARB_RR_EN
        chk("t3_first_m1", first_m1, 1);
        chk("t3_second_m1", second_m1, 3);
        chk("t3_m1_rvalid", first_m1_rv, 2);
`else
        chk("t3_first_m1", first_m1, 8);
        chk("t3_second_m1", second_m1, 17);
        chk("t3_m1_rvalid", first_m1_rv, 9);
`endif
        tick();

        // Back-to-back reads with alternating owners.
        rd0(10'h001);
        tick(); idle(); rd1(10'h002);
        #1 chk("t4_a", {m1_rvalid, m0_rvalid, m0_rdata}, {2'b01, 32'hA5A50001});
        tick(); idle(); rd0(10'h003);
        #1 chk("t4_b", {m1_rvalid, m0_rvalid, m1_rdata}, {2'b10, 32'hA5A50002});
        tick(); idle();
        #1 chk("t4_c", {m1_rvalid, m0_rvalid, m0_rdata}, {2'b01, 32'hA5A50003});
        tick();

        // Reset lands while a read is outstanding.
        rd0(10'h005);
        #1 chk("t5_gnt0", m0_gnt, 1);
        tick(); idle();
        rst_n = 0;
        #1 chk("t5_dropped", m0_rvalid, 0);
        tick();
        rst_n = 1;
        #1 chk("t5_after_release", {m1_rvalid, m0_rvalid}, 0);
        rd0(10'h006);
        #1 chk("t5_regrant", m0_gnt, 1);
        tick(); idle();
        #1 chk("t5_rdata", m0_rdata, 32'hA5A50006);
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
